inst_fetch: RTL

Instruction-fetch front end: the initiator side of the instruction-ROM fetch interface. It owns the PC, issues word fetches to the ROM, which returns the instruction one cycle later, and pairs each returned word with its PC. It buffers the pair in a small FIFO and hands it to decode over a valid/ready handshake. Branch redirects from decode flush the stream, with optional MIPS delay-slot preservation.

---
 rtl/inst_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch -- instruction-fetch front end.
// Owns the PC and issues one word fetch per cycle to the instruction ROM.
// Each response arrives one cycle after its request. It is paired with its
// PC and buffered in a small FIFO, then handed to decode over valid/ready.
// A branch redirect flushes the stream and restarts fetch at the target.
// Optional macro DELAY_SLOT_EN: on a redirect, the oldest undelivered
// instruction is kept as the MIPS delay slot. If that instruction has not
// been fetched yet, a one-shot DRAIN state fetches it before the target.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce,
   output logic [31:0] rom_pc,
   input  logic [31:0] rom_inst,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   input  logic        id_ready,
   input  logic        br_valid,
   input  logic [31:0] br_target
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

   fetch_ent_t    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic [31:0]   pc_q, req_pc_q;
   logic          inflight_q;

   logic [31:0] br_pc, resume_pc;
   logic [CW:0] occ;
   logic        pop, pop_eff, push, flush, keep_head, discard;
   logic        br_take, need_ds, draining, ds_resume, credit_ok, issue;

   // Low two bits of the redirect target are dropped; fetches are word aligned.
   assign br_pc = br_target & 32'hFFFF_FFFC;

`ifdef DELAY_SLOT_EN
   typedef enum logic {RUN, DRAIN} state_t;
   state_t      state_q, state_d;
   logic [31:0] tgt_q;

   assign draining  = (state_q == DRAIN);
   // A redirect seen while the delay slot is still being fetched is dropped.
   assign br_take   = br_valid & ~draining;
   // FIFO head is the delay slot: drop everything behind it, including the
   // in-flight response.
   assign keep_head = br_take & (count_q != '0);
   assign discard   = keep_head;
   assign flush     = 1'b0;
   // Nothing fetched yet that could act as the delay slot.
   assign need_ds   = br_take & (count_q == '0) & ~inflight_q;
   // Delay-slot word arriving this cycle; fetch resumes from the stored target.
   assign ds_resume = draining & inflight_q;
   assign resume_pc = tgt_q;

   // Redirect state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Enter DRAIN when the delay slot must still be fetched; leave it once
   // that single response is captured.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (need_ds)    state_d = DRAIN;
         DRAIN:   if (inflight_q) state_d = RUN;
         default:                 state_d = RUN;
      endcase
   end

   // Redirect target parked while the delay slot is fetched.
   always_ff @(posedge clk) begin
      if (rst)          tgt_q <= '0;
      else if (need_ds) tgt_q <= br_pc;
   end
`else
   assign draining  = 1'b0;
   assign br_take   = br_valid;
   assign keep_head = 1'b0;
   assign discard   = br_valid;
   assign flush     = br_valid;
   assign need_ds   = 1'b0;
   assign ds_resume = 1'b0;
   assign resume_pc = '0;
`endif

   assign id_valid = (count_q != '0);
   assign pop      = id_valid & id_ready;
   // A redirect beats a pop: the head is never handed over in a redirect cycle.
   assign pop_eff  = pop & ~br_take;
   assign push     = inflight_q & ~discard;

   // Occupancy once this cycle settles. Pop is never above count, so there
   // is no underflow.
   assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
   assign credit_ok = (occ < DEPTH_C);

   // Fetch issue: credit-limited in RUN, one delay-slot fetch in DRAIN.
   always_comb begin
      issue = 1'b0;
      if (!rst) begin
         if (draining) issue = ~inflight_q;
         else          issue = ~br_valid & credit_ok;
      end
   end

   assign rom_ce = issue;
   assign rom_pc = pc_q;

   // PC, request-PC and in-flight tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) req_pc_q <= pc_q;
         if (br_take && !need_ds) pc_q <= br_pc;
         else if (ds_resume)      pc_q <= resume_pc;
         else if (issue)          pc_q <= pc_q + 32'd4;
      end
   end

   // FIFO pointers and count. After a delay-slot keep, only the head remains.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (keep_head) begin
         tail_q  <= head_q + 1'b1;
         count_q <= CW'(1);
      end else begin
         if (push)    tail_q <= tail_q + 1'b1;
         if (pop_eff) head_q <= head_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_eff};
      end
   end

   // FIFO storage: capture the returned word together with its request PC.
   always_ff @(posedge clk) begin
      if (!rst && push) fifo_mem[tail_q] <= '{pc: req_pc_q, inst: rom_inst};
   end

   assign id_pc   = id_valid ? fifo_mem[head_q].pc   : '0;
   assign id_inst = id_valid ? fifo_mem[head_q].inst : '0;

endmodule
